// File: rtl/player_health.sv
// rtl/player_health.sv - per-player hit points, invulnerability windows and round-over detection
//
// Purpose: tracks hit points for two players and runs a post-hit invulnerability
// countdown for each one, clocked by video frames. Flags the end of the round
// to the game-state FSM and reports which player or players died.
//
// Ports:
//   Clk        in   system clock, rising edge
//   Reset      in   asynchronous active-low reset
//   frame_clk  in   vsync frame strobe (level, synchronous to Clk)
//   restart    in   reload the round (highest priority)
//   in_game    in   round running
//   p2         in   two-player mode, latched when play starts
//   hit1/hit2  in   single-cycle collision pulses
//   dead       out  round over (state DEAD)
//   hp1/hp2    out  current hit points
//   blink1/2   out  player invulnerable (sprite flash)
//   loser      out  [0] player 1 died, [1] player 2 died
module player_health #(
  parameter int MAX_HP        = 5,
  parameter int INVULN_FRAMES = 60
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       restart,
  input  logic       in_game,
  input  logic       p2,
  input  logic       hit1,
  input  logic       hit2,
  output logic       dead,
  output logic [2:0] hp1,
  output logic [2:0] hp2,
  output logic       blink1,
  output logic       blink2,
  output logic [1:0] loser
);

  localparam logic [2:0] HP_INIT  = 3'(MAX_HP);
  localparam logic [7:0] INV_INIT = 8'(INVULN_FRAMES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_PLAY  = 2'd2,
    S_DEAD  = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_next_state;

  logic       r_frame_d;
  logic [2:0] r_hp1;
  logic [2:0] r_hp2;
  logic [7:0] r_inv1;
  logic [7:0] r_inv2;
  logic       r_two_p;
  logic [1:0] r_loser;

  logic       w_frame_tick;
  logic       w_play_live;
  logic       w_acc1;
  logic       w_acc2;
  logic       w_fatal1;
  logic       w_fatal2;
  logic       w_start;

  assign w_frame_tick = frame_clk & ~r_frame_d;

  // Hits only count in a live PLAY cycle; leaving PLAY (in_game low) or a
  // restart on the same edge discards them.
  assign w_play_live = (r_state == S_PLAY) && in_game && !restart;
  assign w_acc1      = w_play_live && hit1 && (r_inv1 == 8'd0) && (r_hp1 != 3'd0);
  assign w_acc2      = w_play_live && r_two_p && hit2 && (r_inv2 == 8'd0) && (r_hp2 != 3'd0);
  assign w_fatal1    = w_acc1 && (r_hp1 == 3'd1);
  assign w_fatal2    = w_acc2 && (r_hp2 == 3'd1);
  assign w_start     = (r_state == S_ARMED) && in_game && !restart;

  // State register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    if (restart) begin
      w_next_state = S_ARMED;
    end else begin
      case (r_state)
        S_IDLE:  w_next_state = S_IDLE;
        S_ARMED: if (in_game) w_next_state = S_PLAY;
        S_PLAY: begin
          if (!in_game) begin
            w_next_state = S_IDLE;
          end else if (w_fatal1 || w_fatal2) begin
            w_next_state = S_DEAD;
          end
        end
        S_DEAD:  w_next_state = S_DEAD;
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  // Output decode
  always_comb begin
    dead = (r_state == S_DEAD);
  end

  // Frame strobe history
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_frame_d <= 1'b0;
    end else begin
      r_frame_d <= frame_clk;
    end
  end

  // Hit points, invulnerability counters, mode bit and loser flags.
  // An accepted hit reloads the counter and wins over a coincident frame tick.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_hp1   <= 3'd0;
      r_hp2   <= 3'd0;
      r_inv1  <= 8'd0;
      r_inv2  <= 8'd0;
      r_two_p <= 1'b0;
      r_loser <= 2'b00;
    end else if (restart) begin
      r_hp1   <= HP_INIT;
      r_hp2   <= HP_INIT;
      r_inv1  <= 8'd0;
      r_inv2  <= 8'd0;
      r_loser <= 2'b00;
    end else begin
      if (w_start) begin
        r_two_p <= p2;
      end

      if (w_acc1) begin
        r_hp1  <= r_hp1 - 3'd1;
        r_inv1 <= INV_INIT;
      end else if (w_frame_tick && (r_inv1 != 8'd0)) begin
        r_inv1 <= r_inv1 - 8'd1;
      end

      if (w_acc2) begin
        r_hp2  <= r_hp2 - 3'd1;
        r_inv2 <= INV_INIT;
      end else if (w_frame_tick && (r_inv2 != 8'd0)) begin
        r_inv2 <= r_inv2 - 8'd1;
      end

      if (w_fatal1) begin
        r_loser[0] <= 1'b1;
      end
      if (w_fatal2) begin
        r_loser[1] <= 1'b1;
      end
    end
  end

  assign hp1    = r_hp1;
  assign hp2    = r_hp2;
  assign blink1 = (r_inv1 != 8'd0);
  assign blink2 = (r_inv2 != 8'd0);
  assign loser  = r_loser;

endmodule

// File: doc/player_health.md
PLAYER_HEALTH -- requirements
Module: player_health

Interface
REQ-001 The block SHALL have parameter MAX_HP, default 5, giving the starting hit points per player; its legal range is 1..7.
REQ-002 The block SHALL have parameter INVULN_FRAMES, default 60, giving the post-hit invulnerability length in frames; its legal range is 1..255.
REQ-003 Port Clk  input  1  system clock; every register is clocked on its rising edge.
REQ-004 Port Reset  input  1  asynchronous, active-low reset.
REQ-005 Port frame_clk  input  1  vertical-sync frame strobe, level, synchronous to Clk.
REQ-006 Port restart  input  1  level request from the game-state FSM to reload the round.
REQ-007 Port in_game  input  1  high while a round is running.
REQ-008 Port p2  input  1  high while in two-player mode.
REQ-009 Port hit1, hit2  input  1 each  single-cycle collision pulses, one per player.
REQ-010 Port dead  output  1  round-over flag; this signal feeds the game-state FSM.
REQ-011 Port hp1, hp2  output  3 each  current hit points.
REQ-012 Port blink1, blink2  output  1 each  high while the player is invulnerable; used to flash the sprite.
REQ-013 Port loser  output  2  loser[0] = player 1 died; loser[1] = player 2 died.

Function
REQ-014 The block SHALL detect the rising edge of frame_clk using a registered copy of it; the result is frame_tick, one Clk cycle long.
REQ-015 The FSM SHALL have exactly four states:
- IDLE: default state.
- ARMED: counters loaded, waiting for the round to start.
- PLAY: hits are accepted.
- DEAD: round over.
REQ-016 If restart=1 in any state, the next state SHALL be ARMED, with these registers loaded on that edge:
- hp1 = hp2 = MAX_HP
- both invulnerability counters = 0
- loser = 0
REQ-017 restart SHALL have priority over every other input in every state.
REQ-018 From ARMED, in_game=1 and restart=0 SHALL move the FSM to PLAY; on that edge, p2 SHALL be latched into the mode bit two_p.
REQ-019 In PLAY, in_game=0 SHALL move the FSM to IDLE and retain hp values; any hit in that cycle SHALL be ignored.
REQ-020 In PLAY, hit1 SHALL be accepted only when invuln1 = 0 and hp1 > 0.
REQ-021 An accepted hit1 SHALL decrement hp1 by 1 and load invuln1 = INVULN_FRAMES on the same edge.
REQ-022 hit2 SHALL follow the same rules as hit1, using invuln2 and hp2, and SHALL be ignored entirely when two_p = 0.
REQ-023 Each invulnerability counter SHALL decrement by 1 on frame_tick when nonzero and saturate at 0.
REQ-024 An accepted hit SHALL take precedence over a coincident frame_tick for that player's counter.
REQ-025 blinkN SHALL equal (invulnN != 0).
REQ-026 If an accepted hit takes hpN from 1 to 0, the FSM SHALL enter DEAD on that same edge and set loser[N-1] on that same edge; dead is therefore high from the following cycle (1-cycle latency from the hit pulse).
REQ-027 Simultaneous fatal hit1 and hit2 SHALL enter DEAD with loser = 2'b11.
REQ-028 dead SHALL be 1 only in state DEAD, and DEAD SHALL be left only by restart.
REQ-029 In any state other than PLAY, hit1 and hit2 SHALL be ignored.
REQ-030 hp values SHALL never underflow below 0.
REQ-031 The invulnerability counters SHALL continue counting down in IDLE and DEAD.
REQ-032 All outputs SHALL be registered or decoded directly from state/registers, with no combinational path from any input.

Reset
REQ-033 When Reset=0, the block SHALL asynchronously force:
- state = IDLE
- hp1 = hp2 = 0
- invuln1 = invuln2 = 0
- two_p = 0, loser = 0, dead = 0
- the frame_clk history register = 0
REQ-034 An assertion of Reset at any time, including mid-PLAY, SHALL take effect immediately and override restart.
REQ-035 After Reset is released, the block SHALL remain in IDLE until restart=1.

Verification
REQ-036 The bench SHALL cover the following directed scenarios:
- Restart then start: Reset released; restart=1 for 1 cycle; in_game=1 -> hp1 = hp2 = 5, state PLAY, dead = 0, blink1 = 0.
- Invulnerability window: in PLAY with p2=0, hit1 pulse -> hp1 = 4 and blink1 = 1 on the next cycle. A second hit1 before 60 frame_ticks -> hp1 stays 4. After exactly 60 frame_ticks, blink1 = 0, and a third hit1 -> hp1 = 3.
- Fatal hit: with hp1 = 1 and invuln1 = 0, hit1 -> dead = 1 one cycle later, loser = 01, hp1 = 0. Further hit1/hit2 pulses cause no change; restart -> dead = 0, hp1 = 5, loser = 00.
- Two-player simultaneous death: p2=1 latched, hp1 = hp2 = 1, hit1 and hit2 in the same cycle -> dead = 1, loser = 11.
- Single-player hit2 immunity: p2=0 latched, hit2 pulses -> hp2 stays 5 and blink2 stays 0.
- Reset mid-operation: in PLAY with invuln1 = 30, Reset=0 for half a clock period -> all outputs read 0 immediately, before the next Clk edge.
